instr_encoder: RTL
==================

# instr_encoder

Sequential MIPS instruction encoder, the counterpart of the pipeline's instruction-class decoder. It accepts an instruction class plus operand fields over a valid/ready handshake and packs them into 32-bit MIPS words. Each word is buffered in a small FIFO and streamed out with an incrementing instruction address. It sits on the program-load path, where the testbench or loader writes instruction memory starting at the text base.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- BASE_ADDR, 32'h0000_3000, address attached to the first emitted word after reset
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  request carries a valid instruction
- in_ready  out  1  encoder can accept; equals (count < DEPTH) && !reset
- in_class  in  4  class code: NOP=0, ORI=1, LUI=2, ADD=3, SUB=4, JAL=5, LW=6, SW=7, JR=8, BEQ=9; 10–15 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate / offset
- in_index  in  26  jump index for JAL
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer accepts the head
- out_instr  out  32  encoded word at FIFO head
- out_addr  out  32  address of the head word
- count  out  $clog2(DEPTH)+1  current FIFO occupancy
- err  out  1  sticky illegal-class flag (only with ENC_CHECK_EN; otherwise tied 0)

## Operation
- Accept occurs when in_valid && in_ready at a rising edge. The encoded word is pushed into the FIFO the same edge.
- Encoding (op|rs|rt|rd|shamt|funct):
  - ORI: 001101|rs|rt|imm
  - LUI: 001111|00000|rt|imm
  - ADD: 000000|rs|rt|rd|00000|100000
  - SUB: 000000|rs|rt|rd|00000|100010
  - JAL: 000011|index
  - LW: 100011|rs|rt|imm
  - SW: 101011|rs|rt|imm
  - BEQ: 000100|rs|rt|imm
  - JR: 000000|rs|15'b0|001000
  - NOP: 32'h0
- Fields unused by a class are ignored and forced to zero in the output.
- Pop occurs on out_valid && out_ready. On each pop, the address counter increments by 4. It wraps modulo 2^32 with no flag.
- Simultaneous push and pop: occupancy is unchanged. Push is gated only by in_ready, computed from the pre-edge count, so a full FIFO refuses a push even if a pop happens the same cycle.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - out_valid=0, count=0, out_addr=BASE_ADDR, out_instr=0, err=0.
  - in_ready=0 while reset is high and 1 the cycle after.
- Reset mid-stream drops all buffered words and reloads the address counter.
- Latency: a word accepted at edge N is presented with out_valid=1 after edge N. There is no combinational in→out path.
- out_instr and out_addr are held stable while out_valid && !out_ready.

## Configuration
- ENC_CHECK_EN defined:
  - An illegal class (10–15) is accepted (in_ready unaffected) but not pushed.
  - err sets the following cycle and holds until reset.
- ENC_CHECK_EN undefined:
  - An illegal class is pushed as NOP (32'h0).
  - err is constant 0.

## Structure
- Shared package holds:
  - class-code localparams (CLS_NOP … CLS_BEQ)
  - opcode and funct constants (OP_ORI=6'b001101, OP_LUI=6'b001111, OP_JAL=6'b000011, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, FN_ADD=6'b100000, FN_SUB=6'b100010, FN_JR=6'b001000)
  - field bit-ranges shared with the decoder
- One sub-module, instr_fifo: parameterised sync FIFO providing push/pop/count.
- Encoding logic is combinational in the top level.

## Test plan
- ORI rs=0 rt=1 imm=16'h1234, out_ready=1 → out_instr=32'h3401_1234, out_addr=32'h3000 one cycle after accept.
- ADD rs=1 rt=2 rd=3 → 32'h0022_1820; JAL index=26'h000_0C03 → 32'h0C00_0C03; each at the next address (0x3004, 0x3008).
- out_ready=0, push 4 words → in_ready drops after 4th accept, count=4. Release out_ready → words emerge in order at 0x3000..0x300C. Simultaneous push/pop keeps count constant.
- LW rs=29 rt=8 imm=16'hFFFC → 32'h8FA8_FFFC; JR rs=31 with rd=5 driven → 32'h03E0_0008 (rd masked).
- class=12 → with ENC_CHECK_EN: err=1, count unchanged. Without ENC_CHECK_EN: 32'h0 emitted.
- Reset asserted with 3 words buffered → next cycle count=0, out_valid=0, out_addr=32'h3000, in_ready=1 after deassertion.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: class codes, MIPS opcode/funct constants and field bit-ranges
package instr_encoder_pkg;
   localparam logic [3:0] CLS_NOP = 4'd0, CLS_ORI = 4'd1, CLS_LUI = 4'd2, CLS_ADD = 4'd3, CLS_SUB = 4'd4;
   localparam logic [3:0] CLS_JAL = 4'd5, CLS_LW = 4'd6, CLS_SW = 4'd7, CLS_JR = 4'd8, CLS_BEQ = 4'd9;
   localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_JAL = 6'b000011;
   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
   localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_JR = 6'b001000;
   // field bit-ranges shared with the decoder
   localparam int OP_HI = 31, OP_LO = 26, RS_HI = 25, RS_LO = 21, RT_HI = 20, RT_LO = 16;
   localparam int RD_HI = 15, RD_LO = 11, FN_HI = 5, FN_LO = 0;
   localparam int IMM_HI = 15, IMM_LO = 0, IDX_HI = 25, IDX_LO = 0;
   function automatic logic is_legal(input logic [3:0] c);
      return c <= CLS_BEQ;
   endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO with push/pop and occupancy count
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int W = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;
   assign dout = mem[rd_ptr];
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs class + operands into MIPS words, buffers them and streams them with addresses.
// Define ENC_CHECK_EN to drop illegal classes and raise a sticky err instead of emitting NOPs.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_class,
   input  logic [4:0]             in_rs,
   input  logic [4:0]             in_rt,
   input  logic [4:0]             in_rd,
   input  logic [15:0]            in_imm,
   input  logic [25:0]            in_index,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_instr,
   output logic [31:0]            out_addr,
   output logic [$clog2(DEPTH):0] count,
   output logic                   err
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic [31:0] enc, head;
   logic accept, push, pop;
   always_comb begin
      enc = '0;
      enc[OP_HI:OP_LO] = in_class == CLS_ORI ? OP_ORI : in_class == CLS_LUI ? OP_LUI :
                         in_class == CLS_JAL ? OP_JAL : in_class == CLS_LW ? OP_LW :
                         in_class == CLS_SW ? OP_SW : in_class == CLS_BEQ ? OP_BEQ : OP_SPECIAL;
      enc[RS_HI:RS_LO] = in_class inside {CLS_ORI, CLS_ADD, CLS_SUB, CLS_LW, CLS_SW, CLS_BEQ, CLS_JR} ? in_rs : '0;
      enc[RT_HI:RT_LO] = in_class inside {CLS_ORI, CLS_LUI, CLS_ADD, CLS_SUB, CLS_LW, CLS_SW, CLS_BEQ} ? in_rt : '0;
      enc[RD_HI:RD_LO] = in_class inside {CLS_ADD, CLS_SUB} ? in_rd : '0;
      enc[FN_HI:FN_LO] = in_class == CLS_ADD ? FN_ADD : in_class == CLS_SUB ? FN_SUB :
                         in_class == CLS_JR ? FN_JR : '0;
      if (in_class inside {CLS_ORI, CLS_LUI, CLS_LW, CLS_SW, CLS_BEQ}) enc[IMM_HI:IMM_LO] = in_imm;
      if (in_class == CLS_JAL) enc[IDX_HI:IDX_LO] = in_index;
   end
   assign in_ready = (count < CW'(DEPTH)) && !reset;
   assign accept = in_valid && in_ready;
   assign out_valid = count != '0;
   assign pop = out_valid && out_ready;
`ifdef ENC_CHECK_EN
   assign push = accept && is_legal(in_class);
   always_ff @(posedge clk)
      if (reset) err <= 1'b0;
      else if (accept && !is_legal(in_class)) err <= 1'b1;
`else
   assign push = accept;
   assign err = 1'b0;
`endif
   instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(enc), .dout(head), .count(count)
   );
   // empty FIFO presents zero rather than a stale entry
   assign out_instr = out_valid ? head : '0;
   always_ff @(posedge clk)
      if (reset) out_addr <= BASE_ADDR;
      else if (pop) out_addr <= out_addr + 32'd4;
endmodule
